// File: rtl/video_lock_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// video_lock_monitor
//
// Watches the video decoder's lock pin once the reset sequencer has released
// the chip. The pin is synchronised and debounced. An FSM then tracks lock.
// If lock never arrives, or if it is lost for too long, the FSM issues a
// one-cycle re-init request to the reset sequencer. After MAX_RETRY requests
// it enters a sticky FAIL state, which only reset clears.
//
// Optional feature: define LOCK_EVT_EN to add the o_lock_evt and o_loss_cnt
// outputs. Without LOCK_EVT_EN those ports and their logic do not exist.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_seq_done    sequencer finished; chip reset released
//   i_lock_async  decoder lock pin, asynchronous to i_clk
//   o_lock_ok     debounced lock, registered
//   o_reinit_req  one-cycle pulse: restart the reset sequence
//   o_retry_cnt   number of re-init requests issued, saturating
//   o_fail        sticky: retries exhausted
//   o_state       FSM state code, for debug
//   o_lock_evt    (LOCK_EVT_EN) pulse in the cycle after any o_lock_ok change
//   o_loss_cnt    (LOCK_EVT_EN) count of LOCKED->LOSS entries, saturating
// -----------------------------------------------------------------------------
module video_lock_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_CYC      = 1000,
  parameter int unsigned LOCK_TIMEOUT = 5900000,
  parameter int unsigned LOSS_CYC     = 59000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RETRY_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_seq_done,
  input  logic               i_lock_async,
  output logic               o_lock_ok,
  output logic               o_reinit_req,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic               o_fail,
  output logic [2:0]         o_state
`ifdef LOCK_EVT_EN
  ,
  output logic               o_lock_evt,
  output logic [7:0]         o_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_LOSS      = 3'd3,
    ST_REINIT    = 3'd4,
    ST_WAIT_LOW  = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam int unsigned        DEB_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [31:0]        WAIT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]        LOSS_LAST = 32'(LOSS_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  // ---------------------------------------------------------------------------
  // Synchroniser: the last stage is the clean lock level
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_lock_async};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: lock_ok follows lock_s only after DEB_CYC consecutive
  // disagreeing cycles; any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_lock_ok;
  logic             w_disagree;
  logic             w_deb_flip;

  assign w_disagree = w_lock_s ^ r_lock_ok;
  assign w_deb_flip = w_disagree && (r_deb_cnt == DEB_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_deb_cnt <= '0;
      r_lock_ok <= 1'b0;
    end else if (!w_disagree) begin
      r_deb_cnt <= '0;
    end else if (w_deb_flip) begin
      r_deb_cnt <= '0;
      r_lock_ok <= w_lock_s;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock-tracking FSM
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_timer;
  logic [31:0]        w_timer_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_reinit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Event priority in the timed states: seq_done fall, then lock_ok, then
  // timeout. The timer only counts in WAIT_LOCK and LOSS. It is zero
  // everywhere else, so each timed state starts from 0.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_retry_nxt = r_retry;
    w_reinit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_seq_done) begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (!i_seq_done) begin
          w_state_nxt = ST_IDLE;
        end else if (r_lock_ok) begin
          w_state_nxt = ST_LOCKED;
        end else if (r_timer == WAIT_LAST) begin
          w_state_nxt = ST_REINIT;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      ST_LOCKED: begin
        if (!i_seq_done) begin
          w_state_nxt = ST_IDLE;
        end else if (!r_lock_ok) begin
          w_state_nxt = ST_LOSS;
        end
      end
      ST_LOSS: begin
        if (!i_seq_done) begin
          w_state_nxt = ST_IDLE;
        end else if (r_lock_ok) begin
          w_state_nxt = ST_LOCKED;
        end else if (r_timer == LOSS_LAST) begin
          w_state_nxt = ST_REINIT;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      ST_REINIT: begin
        if (r_retry == RETRY_MAX) begin
          w_state_nxt = ST_FAIL;
        end else begin
          w_reinit    = 1'b1;
          w_state_nxt = ST_WAIT_LOW;
          if (r_retry != RETRY_SAT) begin
            w_retry_nxt = r_retry + 1'b1;
          end
        end
      end
      ST_WAIT_LOW: begin
        // Waiting for seq_done to drop stops a stale seq_done from re-arming.
        if (!i_seq_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The pulse is a decode of registered state. A reset therefore drops it
  // on the next cycle.
  assign o_lock_ok    = r_lock_ok;
  assign o_reinit_req = w_reinit;
  assign o_retry_cnt  = r_retry;
  assign o_fail       = (r_state == ST_FAIL);
  assign o_state      = r_state;

`ifdef LOCK_EVT_EN
  // ---------------------------------------------------------------------------
  // Lock event pulse and loss counter
  // ---------------------------------------------------------------------------
  logic       r_lock_ok_d;
  logic       r_lock_evt;
  logic [7:0] r_loss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_ok_d <= 1'b0;
      r_lock_evt  <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      r_lock_ok_d <= r_lock_ok;
      r_lock_evt  <= r_lock_ok ^ r_lock_ok_d;
      if ((r_state == ST_LOCKED) && (w_state_nxt == ST_LOSS) && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  assign o_lock_evt = r_lock_evt;
  assign o_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_video_lock_monitor.sv
`timescale 1ns/1ps
module tb_video_lock_monitor;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int TO    = 50;
  localparam int LOSSC = 10;
  localparam int MAXR  = 2;
  localparam int RW    = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          seq_done   = 1'b0;
  logic          lock_async = 1'b0;
  logic          lock_ok;
  logic          reinit_req;
  logic [RW-1:0] retry_cnt;
  logic          fail;
  logic [2:0]    state;
`ifdef LOCK_EVT_EN
  logic          lock_evt;
  logic [7:0]    loss_cnt;
  localparam int VW = 19;
`else
  localparam int VW = 10;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_lock_monitor #(
    .SYNC_STAGES (SYNC),
    .DEB_CYC     (DEB),
    .LOCK_TIMEOUT(TO),
    .LOSS_CYC    (LOSSC),
    .MAX_RETRY   (MAXR),
    .RETRY_W     (RW)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_seq_done  (seq_done),
    .i_lock_async(lock_async),
    .o_lock_ok   (lock_ok),
    .o_reinit_req(reinit_req),
    .o_retry_cnt (retry_cnt),
    .o_fail      (fail),
    .o_state     (state)
`ifdef LOCK_EVT_EN
    ,
    .o_lock_evt  (lock_evt),
    .o_loss_cnt  (loss_cnt)
`endif
  );

  logic [VW-1:0] dut_vec;
`ifdef LOCK_EVT_EN
  assign dut_vec = {lock_ok, reinit_req, fail, state, retry_cnt, lock_evt, loss_cnt};
`else
  assign dut_vec = {lock_ok, reinit_req, fail, state, retry_cnt};
`endif

  // ---------------------------------------------------------------------------
  // Reference model. Delay line as a queue, debounce as a run length, and
  // timed states as the elapsed cycle count since entry.
  // ---------------------------------------------------------------------------
  bit m_hist[$];
  int m_run;
  bit m_ok;
  int m_st;
  int m_since;
  int m_cyc = 0;
  int m_retry;
  bit m_pulse;
  bit m_evt;
  bit m_flip_prev;
  int m_losses;

  function automatic void model_step(input bit r, input bit sd, input bit la);
    bit s_old;
    bit ok_old;
    bit flip;
    m_cyc++;
    if (r) begin
      m_hist.delete();
      for (int unsigned i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_run = 0; m_ok = 0; m_st = 0; m_since = 0; m_retry = 0;
      m_pulse = 0; m_evt = 0; m_flip_prev = 0; m_losses = 0;
      return;
    end
    ok_old = m_ok;
    s_old  = m_hist[0];
    m_hist.push_back(la);
    void'(m_hist.pop_front());
    flip = 0;
    if (s_old != ok_old) begin
      m_run++;
      if (m_run == DEB) begin
        m_ok  = s_old;
        m_run = 0;
        flip  = 1;
      end
    end else begin
      m_run = 0;
    end
    m_evt       = m_flip_prev;
    m_flip_prev = flip;
    case (m_st)
      0: if (sd) begin m_st = 1; m_since = m_cyc; end
      1: if (!sd) m_st = 0;
         else if (ok_old) m_st = 2;
         else if (m_cyc - m_since == TO) m_st = 4;
      2: if (!sd) m_st = 0;
         else if (!ok_old) begin
           m_st = 3; m_since = m_cyc;
           if (m_losses < 255) m_losses++;
         end
      3: if (!sd) m_st = 0;
         else if (ok_old) m_st = 2;
         else if (m_cyc - m_since == LOSSC) m_st = 4;
      4: if (m_retry == MAXR) m_st = 6;
         else begin
           if (m_retry < (2 ** RW) - 1) m_retry++;
           m_st = 5;
         end
      5: if (!sd) m_st = 0;
      default: ;
    endcase
    m_pulse = (m_st == 4) && (m_retry != MAXR);
  endfunction

  function automatic logic [VW-1:0] model_vec();
`ifdef LOCK_EVT_EN
    return {m_ok, m_pulse, (m_st == 6), 3'(m_st), RW'(m_retry), m_evt, 8'(m_losses)};
`else
    return {m_ok, m_pulse, (m_st == 6), 3'(m_st), RW'(m_retry)};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, seq_done, lock_async);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; seq_done = 1'b1; lock_async = 1'b1;
    tick(); tick();
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL reset_vec got=%h want=0", dut_vec);
    end
    rst = 1'b0; seq_done = 1'b0; lock_async = 1'b0;
  endtask

  task automatic test_lock_acquire();
    int n;
    bit seen;
    seq_done = 1'b1; lock_async = 1'b0;
    repeat (5) begin
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL acq_pre t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    lock_async = 1'b1; n = 0; seen = 0;
    while (n < 30 && !seen) begin
      tick(); n++; total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL acq t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
      if (lock_ok === 1'b1) seen = 1;
    end
    total++;
    if (!seen || n != SYNC + DEB) begin
      bad++; $display("FAIL acq_latency got=%0d seen=%0d want=%0d", n, seen, SYNC + DEB);
    end
    repeat (3) begin
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL acq_post t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    total++;
    if (state !== 3'd2 || reinit_req !== 1'b0) begin
      bad++; $display("FAIL acq_state got=%0d/%b want=2/0", state, reinit_req);
    end
  endtask

  task automatic test_short_pulse();
    int n;
    int pulses;
    bit ok_seen;
    seq_done = 1'b0; lock_async = 1'b0;
    repeat (10) begin
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL sp_idle t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    seq_done = 1'b1;
    repeat ($urandom_range(0, 5)) tick();
    lock_async = 1'b1;
    repeat (3) tick();
    lock_async = 1'b0;
    n = 0; pulses = 0; ok_seen = 0;
    while (n < 80 && state !== 3'd5) begin
      tick(); n++; total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL sp t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
      if (reinit_req === 1'b1) pulses++;
      if (lock_ok === 1'b1) ok_seen = 1;
    end
    repeat (5) begin
      tick();
      if (reinit_req === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1 || retry_cnt !== 4'd1 || ok_seen || state !== 3'd5) begin
      bad++;
      $display("FAIL sp_result pulses/retry/ok/state got=%0d/%0d/%0d/%0d want=1/1/0/5",
               pulses, retry_cnt, ok_seen, state);
    end
  endtask

  task automatic test_loss_recover();
    int nlow;
    int pulses;
    seq_done = 1'b0;
    tick();
    seq_done = 1'b1; lock_async = 1'b1;
    repeat (15) begin
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL rec_acq t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    total++;
    if (state !== 3'd2) begin
      bad++; $display("FAIL rec_locked got=%0d want=2", state);
    end
    nlow = $urandom_range(DEB, LOSSC - 1);
    lock_async = 1'b0;
    repeat (nlow) tick();
    lock_async = 1'b1;
    pulses = 0;
    repeat (25) begin
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL rec t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
      if (reinit_req === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || state !== 3'd2 || retry_cnt !== 4'd1) begin
      bad++;
      $display("FAIL rec_result low=%0d pulses/state/retry got=%0d/%0d/%0d want=0/2/1",
               nlow, pulses, state, retry_cnt);
    end
  endtask

  task automatic test_loss_reinit();
    int n;
    bit seen;
    lock_async = 1'b0; n = 0; seen = 0;
    while (n < 60 && !seen) begin
      tick(); n++; total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL ri t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
      if (reinit_req === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL ri_pulse got=none want=pulse within 60");
    end
    repeat (4) tick();
    total++;
    if (state !== 3'd5 || reinit_req !== 1'b0) begin
      bad++; $display("FAIL ri_waitlow got=%0d/%b want=5/0", state, reinit_req);
    end
    seq_done = 1'b0;
    tick();
    total++;
    if (state !== 3'd0 || retry_cnt !== 4'd2) begin
      bad++; $display("FAIL ri_idle state/retry got=%0d/%0d want=0/2", state, retry_cnt);
    end
  endtask

  task automatic test_fail();
    int n;
    int pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0; seq_done = 1'b1; lock_async = 1'b0;
    n = 0; pulses = 0;
    while (n < 400 && state !== 3'd6) begin
      tick(); n++; total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL fl t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
      if (reinit_req === 1'b1) pulses++;
      seq_done = (state === 3'd5) ? 1'b0 : 1'b1;
    end
    total++;
    if (pulses != MAXR || fail !== 1'b1 || state !== 3'd6 || retry_cnt !== 4'(MAXR)) begin
      bad++;
      $display("FAIL fl_result pulses/fail/state/retry got=%0d/%b/%0d/%0d want=%0d/1/6/%0d",
               pulses, fail, state, retry_cnt, MAXR, MAXR);
    end
    repeat (40) begin
      seq_done   = 1'($urandom_range(0, 1));
      lock_async = 1'($urandom_range(0, 1));
      tick();
    end
    total++;
    if (fail !== 1'b1 || state !== 3'd6 || reinit_req !== 1'b0) begin
      bad++; $display("FAIL fl_sticky fail/state got=%b/%0d want=1/6", fail, state);
    end
  endtask

  task automatic test_reset_in_loss();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0; seq_done = 1'b1; lock_async = 1'b1;
    repeat (15) tick();
    lock_async = 1'b0; n = 0;
    while (n < 30 && state !== 3'd3) begin
      tick(); n++; total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL rl t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    repeat (7) tick();
    total++;
    if (state !== 3'd3 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL rl_loss got=%h want=%h (state 3)", dut_vec, model_vec());
    end
`ifdef LOCK_EVT_EN
    total++;
    if (loss_cnt !== 8'd1) begin
      bad++; $display("FAIL rl_loss_cnt got=%0d want=1", loss_cnt);
    end
`endif
    rst = 1'b1;
    tick();
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL rl_reset got=%h want=0", dut_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0; seq_done = 1'b0; lock_async = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0)   lock_async = ~lock_async;
      if ($urandom_range(0, 39) == 0)  seq_done   = ~seq_done;
      rst = ($urandom_range(0, 299) == 0);
      tick(); total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL rnd t=%0d got=%h want=%h", m_cyc, dut_vec, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_short_pulse();
    test_loss_recover();
    test_loss_reinit();
    test_fail();
    test_reset_in_loss();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
